// File: rtl/sha_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// sha_mem_responder_pkg
//   Shared types and constants for the SHA-256 memory responder slice.
//   - state_t        : sequencer FSM states
//   - HASH_WORDS     : digest length in 32-bit words
//   - DEF_*          : default parameter values for the responder
//   - addr_in_range  : true when a 16-bit word address falls inside a RAM of
//                      2**addr_w words
// -----------------------------------------------------------------------------
package sha_mem_responder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_ARM,
      ST_RUN,
      ST_DRAIN,
      ST_DRAIN_WAIT
   } state_t;

   localparam int HASH_WORDS    = 8;
   localparam int DEF_NUM_WORDS = 20;
   localparam int DEF_TIMEOUT   = 4096;
   localparam int DEF_ADDR_W    = 8;

   // Any address bit at or above addr_w means the access is outside the RAM.
   function automatic logic addr_in_range(input logic [15:0] addr, input int addr_w);
      if (addr_w >= 16) begin
         return 1'b1;
      end
      return ((32'(addr) >> addr_w) == 32'd0);
   endfunction

endpackage

// File: rtl/sha_mem_responder_if.sv
// -----------------------------------------------------------------------------
// sha_mem_responder_if
//   Bundles the host message/digest streams and the engine memory-master port.
//   Host stream : in_valid/in_ready/in_data (message in),
//                 out_valid/out_ready/out_data/out_last (digest out)
//   Engine      : sha_start, sha_msg_addr, sha_out_addr, sha_done,
//                 mem_we, mem_addr, mem_write_data, mem_read_data
//   slave  modport : responder view
//   master modport : host + engine view
// -----------------------------------------------------------------------------
interface sha_mem_responder_if;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;
   logic        sha_start;
   logic [15:0] sha_msg_addr;
   logic [15:0] sha_out_addr;
   logic        sha_done;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   modport slave (
      input  in_valid, in_data, out_ready, sha_done,
             mem_we, mem_addr, mem_write_data,
      output in_ready, out_valid, out_data, out_last,
             sha_start, sha_msg_addr, sha_out_addr, mem_read_data
   );

   modport master (
      output in_valid, in_data, out_ready, sha_done,
             mem_we, mem_addr, mem_write_data,
      input  in_ready, out_valid, out_data, out_last,
             sha_start, sha_msg_addr, sha_out_addr, mem_read_data
   );

endinterface

// File: rtl/sha_mem_responder_word_ram.sv
// -----------------------------------------------------------------------------
// sha_mem_responder_word_ram
//   2**ADDR_W x 32 word RAM, single clock.
//   Port A : read/write. Write when a_we && a_ok; registered read when a_rd
//            (a_rdata holds its value otherwise, which keeps streamed data
//            stable). Out-of-range reads (a_ok=0) return 0.
//   Port B : read only, registered every cycle; out-of-range (b_ok=0) gives 0.
//   Both reads see the array contents from before a same-cycle write
//   (read-first). Output registers reset to 0; the array itself is not reset.
// Ports: clk, reset_n, a_we, a_rd, a_ok, a_addr, a_wdata, a_rdata,
//        b_ok, b_addr, b_rdata
// -----------------------------------------------------------------------------
module sha_mem_responder_word_ram #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              a_we,
   input  logic              a_rd,
   input  logic              a_ok,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [31:0]       a_wdata,
   output logic [31:0]       a_rdata,
   input  logic              b_ok,
   input  logic [ADDR_W-1:0] b_addr,
   output logic [31:0]       b_rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [31:0] mem [DEPTH];
   logic [31:0] a_rdata_reg;
   logic [31:0] b_rdata_reg;

   // Array write kept apart from the reset logic so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (a_we && a_ok) begin
         mem[a_addr] <= a_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_rdata_reg <= '0;
      end else if (a_rd) begin
         a_rdata_reg <= a_ok ? mem[a_addr] : '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         b_rdata_reg <= '0;
      end else begin
         b_rdata_reg <= b_ok ? mem[b_addr] : '0;
      end
   end

   assign a_rdata = a_rdata_reg;
   assign b_rdata = b_rdata_reg;

endmodule

// File: rtl/sha_mem_responder.sv
// -----------------------------------------------------------------------------
// sha_mem_responder
//   Memory-side responder and host sequencer for the SHA-256 engine.
//   Loads NUM_WORDS message words from the host stream into the word RAM,
//   pulses sha_start, waits for the engine to finish (bounded by TIMEOUT
//   cycles) and streams the 8-word digest back to the host.
//   The engine memory port is served in every state with 1-cycle read latency.
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   cfg_msg_addr, cfg_out_addr message/digest word addresses, sampled on the
//                              first accepted word in IDLE
//   busy                       high in every state except IDLE
//   err_timeout                sticky engine timeout flag
//   bus (slave)                host streams + engine memory-master port
// -----------------------------------------------------------------------------
module sha_mem_responder
   import sha_mem_responder_pkg::*;
#(
   parameter int NUM_WORDS = DEF_NUM_WORDS,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int TIMEOUT   = DEF_TIMEOUT
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [15:0]          cfg_msg_addr,
   input  logic [15:0]          cfg_out_addr,
   output logic                 busy,
   output logic                 err_timeout,
   sha_mem_responder_if.slave   bus
);

   state_t      state_reg,  state_next;
   logic [15:0] cnt_reg,    cnt_next;
   logic [15:0] msg_reg,    msg_next;
   logic [15:0] out_reg,    out_next;
   logic [2:0]  k_reg,      k_next;
   logic [31:0] tcnt_reg,   tcnt_next;
   logic        err_reg,    err_next;

   logic        load_state;
   logic        in_fire;
   logic        host_we;
   logic        drain_rd;
   logic [15:0] host_addr;
   logic [15:0] drain_addr;
   logic [15:0] a_addr_full;
   logic        ram_a_we;
   logic        ram_a_ok;
   logic        ram_b_ok;
   logic [31:0] ram_a_wdata;

   assign load_state = (state_reg == ST_IDLE) || (state_reg == ST_LOAD);
   // Port A carries both engine writes and host writes; an engine write owns
   // the port, so the host is stalled for that cycle instead of losing a word.
   assign bus.in_ready = reset_n && load_state && !bus.mem_we;
   assign in_fire      = bus.in_ready && bus.in_valid;
   assign drain_addr   = out_reg + 16'(k_reg);

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      msg_next   = msg_reg;
      out_next   = out_reg;
      k_next     = k_reg;
      tcnt_next  = tcnt_reg;
      err_next   = err_reg;
      host_we    = 1'b0;
      host_addr  = msg_reg + cnt_reg;
      drain_rd   = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            host_addr = cfg_msg_addr;
            if (in_fire) begin
               host_we    = 1'b1;
               msg_next   = cfg_msg_addr;
               out_next   = cfg_out_addr;
               err_next   = 1'b0;
               cnt_next   = 16'd1;
               state_next = (NUM_WORDS == 1) ? ST_START : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (in_fire) begin
               host_we  = 1'b1;
               cnt_next = cnt_reg + 16'd1;
               if (cnt_reg == 16'(NUM_WORDS - 1)) begin
                  state_next = ST_START;
               end
            end
         end
         ST_START: begin
            tcnt_next  = '0;
            state_next = ST_ARM;
         end
         ST_ARM: begin
            // Engine done is high before start; wait for it to drop.
            tcnt_next = tcnt_reg + 32'd1;
            if (tcnt_reg == 32'(TIMEOUT - 1)) begin
               err_next   = 1'b1;
               state_next = ST_IDLE;
            end else if (!bus.sha_done) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            tcnt_next = tcnt_reg + 32'd1;
            if (bus.sha_done) begin
               k_next     = '0;
               state_next = ST_DRAIN;
            end else if (tcnt_reg == 32'(TIMEOUT - 1)) begin
               err_next   = 1'b1;
               state_next = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            // An engine write takes port A; retry the digest read next cycle.
            if (!bus.mem_we) begin
               drain_rd   = 1'b1;
               state_next = ST_DRAIN_WAIT;
            end
         end
         ST_DRAIN_WAIT: begin
            if (bus.out_ready) begin
               if (k_reg == 3'(HASH_WORDS - 1)) begin
                  state_next = ST_IDLE;
               end else begin
                  k_next     = k_reg + 3'd1;
                  state_next = ST_DRAIN;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         msg_reg   <= '0;
         out_reg   <= '0;
         k_reg     <= '0;
         tcnt_reg  <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         msg_reg   <= msg_next;
         out_reg   <= out_next;
         k_reg     <= k_next;
         tcnt_reg  <= tcnt_next;
         err_reg   <= err_next;
      end
   end

   // Port A address: engine write first, then digest read, then host write.
   assign a_addr_full = bus.mem_we ? bus.mem_addr :
                        (state_reg == ST_DRAIN) ? drain_addr : host_addr;
   assign ram_a_we    = bus.mem_we || host_we;
   assign ram_a_wdata = bus.mem_we ? bus.mem_write_data : bus.in_data;
   assign ram_a_ok    = addr_in_range(a_addr_full, ADDR_W);
   assign ram_b_ok    = addr_in_range(bus.mem_addr, ADDR_W);

   sha_mem_responder_word_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .a_we    (ram_a_we),
      .a_rd    (drain_rd),
      .a_ok    (ram_a_ok),
      .a_addr  (a_addr_full[ADDR_W-1:0]),
      .a_wdata (ram_a_wdata),
      .a_rdata (bus.out_data),
      .b_ok    (ram_b_ok),
      .b_addr  (bus.mem_addr[ADDR_W-1:0]),
      .b_rdata (bus.mem_read_data)
   );

   assign bus.out_valid    = (state_reg == ST_DRAIN_WAIT);
   assign bus.out_last     = (state_reg == ST_DRAIN_WAIT) && (k_reg == 3'(HASH_WORDS - 1));
   assign bus.sha_start    = (state_reg == ST_START);
   assign bus.sha_msg_addr = msg_reg;
   assign bus.sha_out_addr = out_reg;
   assign busy             = (state_reg != ST_IDLE);
   assign err_timeout      = err_reg;

endmodule

// File: tb/tb_sha_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_sha_mem_responder
//   Directed bench for sha_mem_responder with a hand-driven engine stub.
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sha_mem_responder;

   logic        clk;
   logic        reset_n;
   logic [15:0] cfg_msg_addr;
   logic [15:0] cfg_out_addr;
   logic        busy;
   logic        err_timeout;

   int n_tests;
   int n_fail;

   sha_mem_responder_if bus ();

   sha_mem_responder #(
      .NUM_WORDS (20),
      .ADDR_W    (8),
      .TIMEOUT   (64)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .cfg_msg_addr (cfg_msg_addr),
      .cfg_out_addr (cfg_out_addr),
      .busy         (busy),
      .err_timeout  (err_timeout),
      .bus          (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = 0x%08h", tag, got);
      end
   endtask

   // Sends words base+first .. base+first+count-1; returns on the falling edge
   // right after the last handshake.
   task automatic load_msg(input logic [15:0] msg, input logic [15:0] out,
                           input logic [31:0] base, input int first, input int count);
      int n;
      cfg_msg_addr = msg;
      cfg_out_addr = out;
      for (int i = first; i < first + count; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = base + 32'(i);
         n = 0;
         while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (n >= 50) check("load_ready_wait", 32'(n), 32'd0);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
   endtask

   // Receives 8 digest words expected as 0xA0..0xA7.
   task automatic drain_check(input string tag, input bit stall, input bit contend);
      int n;
      logic [31:0] exp;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         exp = 32'hA0 + 32'(k);
         if (contend && k == 5) begin
            bus.mem_addr       = 16'h0090;
            bus.mem_write_data = 32'h99;
            bus.mem_we         = 1'b1;
            @(negedge clk);
            @(negedge clk);
            check({tag, "_blocked_valid"}, 32'(bus.out_valid), 32'd0);
            bus.mem_we = 1'b0;
         end
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!bus.out_valid && n < 30);
         if (n >= 30) check({tag, "_valid_wait"}, 32'(n), 32'd0);
         check($sformatf("%s_data[%0d]", tag, k), bus.out_data, exp);
         check($sformatf("%s_last[%0d]", tag, k), 32'(bus.out_last), 32'(k == 7));
         if (stall && k == 3) begin
            bus.out_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               @(negedge clk);
               check($sformatf("%s_stall_data[%0d]", tag, s), bus.out_data, exp);
               check($sformatf("%s_stall_valid[%0d]", tag, s), 32'(bus.out_valid), 32'd1);
            end
            bus.out_ready = 1'b1;
         end
      end
   endtask

   initial begin
      int n;
      n_tests            = 0;
      n_fail             = 0;
      reset_n            = 1'b0;
      cfg_msg_addr       = '0;
      cfg_out_addr       = '0;
      bus.in_valid       = 1'b0;
      bus.in_data        = '0;
      bus.out_ready      = 1'b0;
      bus.sha_done       = 1'b1;
      bus.mem_we         = 1'b0;
      bus.mem_addr       = '0;
      bus.mem_write_data = '0;

      repeat (3) @(negedge clk);
      check("rst_in_ready",  32'(bus.in_ready),  32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_last",  32'(bus.out_last),  32'd0);
      check("rst_sha_start", 32'(bus.sha_start), 32'd0);
      check("rst_busy",      32'(busy),          32'd0);
      check("rst_err",       32'(err_timeout),   32'd0);
      check("rst_out_data",  bus.out_data,       32'd0);
      check("rst_mem_rd",    bus.mem_read_data,  32'd0);
      check("rst_msg_addr",  32'(bus.sha_msg_addr), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("idle_in_ready", 32'(bus.in_ready), 32'd1);

      // ---- Run 1: load 0..19 at 0x0000, engine writes digest at 0x0060 ----
      load_msg(16'h0000, 16'h0060, 32'h0, 0, 20);
      check("r1_start",      32'(bus.sha_start), 32'd1);
      check("r1_busy",       32'(busy),          32'd1);
      check("r1_in_ready",   32'(bus.in_ready),  32'd0);
      check("r1_out_addr",   32'(bus.sha_out_addr), 32'h60);
      bus.sha_done = 1'b0;
      @(negedge clk);
      check("r1_start_once", 32'(bus.sha_start), 32'd0);
      for (int i = 0; i < 20; i++) begin
         bus.mem_addr = 16'(i);
         @(negedge clk);
         check($sformatf("ram_rd[%0d]", i), bus.mem_read_data, 32'(i));
      end
      bus.mem_addr = 16'h0003;
      @(negedge clk);
      check("rd_addr3", bus.mem_read_data, 32'h3);
      bus.mem_addr = 16'h0100;
      @(negedge clk);
      check("rd_oor_100", bus.mem_read_data, 32'h0);
      bus.mem_addr = 16'h0103;
      @(negedge clk);
      check("rd_oor_103", bus.mem_read_data, 32'h0);
      bus.mem_addr       = 16'h0005;
      bus.mem_write_data = 32'h55;
      bus.mem_we         = 1'b1;
      @(negedge clk);
      bus.mem_we = 1'b0;
      check("read_first", bus.mem_read_data, 32'h5);
      @(negedge clk);
      check("write_then_read", bus.mem_read_data, 32'h55);
      for (int i = 0; i < 8; i++) begin
         bus.mem_addr       = 16'h0060 + 16'(i);
         bus.mem_write_data = 32'hA0 + 32'(i);
         bus.mem_we         = 1'b1;
         @(negedge clk);
      end
      // Out-of-range write that would alias onto 0x0061 if not dropped.
      bus.mem_addr       = 16'h0161;
      bus.mem_write_data = 32'hDEAD;
      @(negedge clk);
      bus.mem_we = 1'b0;
      check("r1_run_busy", 32'(busy), 32'd1);
      bus.sha_done = 1'b1;
      drain_check("d1", 1'b1, 1'b1);
      @(negedge clk);
      check("d1_idle", 32'(busy), 32'd0);

      // ---- Run 2: engine never finishes ----
      load_msg(16'h0020, 16'h0060, 32'h100, 0, 20);
      check("r2_start", 32'(bus.sha_start), 32'd1);
      bus.sha_done = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!err_timeout && n < 200);
      check("timeout_cycles", 32'(n), 32'd65);
      check("timeout_err",    32'(err_timeout), 32'd1);
      check("timeout_idle",   32'(busy), 32'd0);
      check("timeout_no_out", 32'(bus.out_valid), 32'd0);
      check("r2_msg_addr",    32'(bus.sha_msg_addr), 32'h20);
      bus.sha_done = 1'b1;

      // ---- Run 3: err clears on the next load, then reset during RUN ----
      load_msg(16'h0020, 16'h0060, 32'h300, 0, 1);
      check("err_clear", 32'(err_timeout), 32'd0);
      check("r3_busy",   32'(busy), 32'd1);
      load_msg(16'h0020, 16'h0060, 32'h300, 1, 19);
      check("r3_start", 32'(bus.sha_start), 32'd1);
      bus.sha_done = 1'b0;
      repeat (5) @(negedge clk);
      check("r3_run_busy", 32'(busy), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_busy",      32'(busy),          32'd0);
      check("mid_rst_in_ready",  32'(bus.in_ready),  32'd0);
      check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_start",     32'(bus.sha_start), 32'd0);
      check("mid_rst_out_data",  bus.out_data,       32'd0);
      check("mid_rst_mem_rd",    bus.mem_read_data,  32'd0);
      check("mid_rst_msg_addr",  32'(bus.sha_msg_addr), 32'd0);
      check("mid_rst_out_addr",  32'(bus.sha_out_addr), 32'd0);
      @(negedge clk);
      reset_n      = 1'b1;
      bus.sha_done = 1'b1;
      @(negedge clk);

      // ---- Run 4: normal operation after reset ----
      load_msg(16'h0040, 16'h0060, 32'h200, 0, 20);
      check("r4_start", 32'(bus.sha_start), 32'd1);
      bus.sha_done = 1'b0;
      @(negedge clk);
      bus.mem_addr = 16'h0053;
      @(negedge clk);
      check("r4_rd_last", bus.mem_read_data, 32'h213);
      bus.mem_addr = 16'h0040;
      @(negedge clk);
      check("r4_rd_first", bus.mem_read_data, 32'h200);
      bus.sha_done = 1'b1;
      drain_check("d2", 1'b0, 1'b0);
      @(negedge clk);
      check("d2_idle", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
